// File: rtl/commit_mon_pkg.sv
// Shared definitions for commit_run_monitor: FSM state encoding, dump word
// indices and the index-width helper.
package commit_mon_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } mon_state_e;

    localparam int HDR_IDX = 0;

    // The perf words follow the register words, so they depend on NREGS.
    function automatic int perf_cyc_idx(input int nregs);
        return nregs;
    endfunction

    function automatic int perf_ret_idx(input int nregs);
        return nregs + 1;
    endfunction

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/dump_stream_reg.sv
// One-entry valid/ready output register. A word is captured on load and is
// held stable until the consumer takes it.
module dump_stream_reg #(
    parameter int W  = 32,
    parameter int IW = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [IW-1:0] load_index,
    input  logic [W-1:0]  load_data,
    input  logic          ready,
    output logic          valid,
    output logic [IW-1:0] index,
    output logic [W-1:0]  data
);

    // Capture on load, retire on handshake, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            index <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            index <= load_index;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/commit_run_monitor.sv
// Run controller: watches committed PCs, stops on HALT_PC or cycle limit and
// streams a register snapshot. Define PERF_COUNT_EN to append cycle/retire words.
module commit_run_monitor
    import commit_mon_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              NREGS      = 32,
    parameter int              CNT_W      = 32,
    parameter logic [XLEN-1:0] HALT_PC    = 32'h0000_0048,
    parameter int              MAX_CYCLES = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      commit_valid,
    input  logic [XLEN-1:0]           commit_pc,
    output logic [clog2(NREGS)-1:0]   rf_raddr,
    input  logic [XLEN-1:0]           rf_rdata,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [clog2(NREGS):0]     dump_index,
    output logic [XLEN-1:0]           dump_data,
    output logic                      cpu_freeze,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int AW = clog2(NREGS);
    localparam int IW = AW + 1;
`ifdef PERF_COUNT_EN
    localparam int LAST_IDX = perf_ret_idx(NREGS);
`else
    localparam int LAST_IDX = NREGS - 1;
`endif

    mon_state_e      state_r;
    mon_state_e      state_s;
    logic [CNT_W-1:0] cycle_r;
    logic [XLEN-1:0] last_pc_r;
    logic [XLEN-1:0] halt_pc_r;
    logic            timeout_r;
    logic            done_r;
    logic            freeze_r;
    logic [IW-1:0]   load_idx_r;
    logic            loaded_all_r;
    logic [AW-1:0]   rf_raddr_r;
    logic            halt_hit_s;
    logic            limit_hit_s;
    logic            hs_s;
    logic            load_s;
    logic            last_hs_s;
    logic [XLEN-1:0] word_s;
    logic [IW-1:0]   word_idx_s;
`ifdef PERF_COUNT_EN
    logic [CNT_W-1:0] retire_r;
`endif

    assign halt_hit_s  = commit_valid && (commit_pc == HALT_PC);
    assign limit_hit_s = (cycle_r == CNT_W'(MAX_CYCLES - 1));
    assign hs_s        = dump_valid && dump_ready;
    assign load_s      = (state_r == DUMP) && !loaded_all_r && (!dump_valid || dump_ready);
    // Only one word is ever outstanding, so once everything is loaded the
    // next handshake is the final one.
    assign last_hs_s   = hs_s && loaded_all_r;

    // Next-state logic; halt is checked first so it wins over the limit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (halt_hit_s || limit_hit_s) begin
                    state_s = DUMP;
                end else begin
                    state_s = RUN;
                end
            end
            DUMP: begin
                if (last_hs_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DUMP;
                end
            end
            DONE:    state_s = DONE;
            default: state_s = DONE;
        endcase
    end

    // Selects the word to load for the current dump position.
    always_comb begin
        word_s = '0;
        if (load_idx_r == IW'(HDR_IDX)) begin
            word_s = halt_pc_r;
        end else if (load_idx_r < IW'(NREGS)) begin
            word_s = rf_rdata;
`ifdef PERF_COUNT_EN
        end else if (load_idx_r == IW'(perf_cyc_idx(NREGS))) begin
            word_s = XLEN'(cycle_r);
        end else begin
            word_s = XLEN'(retire_r);
`else
        end else begin
            word_s = '0;
`endif
        end
    end

`ifdef PERF_COUNT_EN
    assign word_idx_s = load_idx_r;
`else
    assign word_idx_s = {1'b0, load_idx_r[AW-1:0]};
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Run-phase bookkeeping: cycle count, last PC and stop cause.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_r   <= '0;
            last_pc_r <= '0;
            halt_pc_r <= '0;
            timeout_r <= 1'b0;
        end else if (state_r == RUN) begin
            cycle_r <= cycle_r + CNT_W'(1);
            if (commit_valid) begin
                last_pc_r <= commit_pc;
            end
            if (halt_hit_s) begin
                halt_pc_r <= commit_pc;
                timeout_r <= 1'b0;
            end else if (limit_hit_s) begin
                halt_pc_r <= commit_valid ? commit_pc : last_pc_r;
                timeout_r <= 1'b1;
            end
        end else begin
            cycle_r <= cycle_r;
        end
    end

`ifdef PERF_COUNT_EN
    // Retired-instruction counter, including the halting commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_r <= '0;
        end else if ((state_r == RUN) && commit_valid) begin
            retire_r <= retire_r + CNT_W'(1);
        end else begin
            retire_r <= retire_r;
        end
    end
`endif

    // Dump sequencing: word pointer, rf read address and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_idx_r   <= '0;
            loaded_all_r <= 1'b0;
            rf_raddr_r   <= AW'(1);
            done_r       <= 1'b0;
            freeze_r     <= 1'b0;
        end else begin
            if (load_s) begin
                load_idx_r   <= load_idx_r + IW'(1);
                rf_raddr_r   <= AW'(load_idx_r + IW'(1));
                loaded_all_r <= (load_idx_r == IW'(LAST_IDX));
            end
            done_r   <= done_r | last_hs_s;
            freeze_r <= (state_s != RUN);
        end
    end

    dump_stream_reg #(
        .W  (XLEN),
        .IW (IW)
    ) u_stream (
        .clock      (clock),
        .reset      (reset),
        .load       (load_s),
        .load_index (word_idx_s),
        .load_data  (word_s),
        .ready      (dump_ready),
        .valid      (dump_valid),
        .index      (dump_index),
        .data       (dump_data)
    );

    assign rf_raddr    = rf_raddr_r;
    assign cpu_freeze  = freeze_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign cycle_count = cycle_r;

endmodule

// File: tb/tb_commit_run_monitor.sv
// Directed bench for commit_run_monitor: halt, timeout, simultaneous stop,
// backpressure, reset mid-dump and (with PERF_COUNT_EN) perf words.
module tb_commit_run_monitor;

`ifdef PERF_COUNT_EN
    localparam int NW = 34;
`else
    localparam int NW = 32;
`endif

    logic        clock;
    logic        rst   [2];
    logic        cv    [2];
    logic [31:0] cpc   [2];
    logic [4:0]  ra    [2];
    logic [31:0] rfd   [2];
    logic        dv    [2];
    logic        rdy   [2];
    logic [5:0]  di    [2];
    logic [31:0] dd    [2];
    logic        frz   [2];
    logic        dn    [2];
    logic        to    [2];
    logic [31:0] cc    [2];

    int n_checks;
    int n_fail;

    // Register file model: rk = k * 0x11.
    assign rfd[0] = {27'd0, ra[0]} * 32'h11;
    assign rfd[1] = {27'd0, ra[1]} * 32'h11;

    commit_run_monitor dut_a (
        .clock(clock), .reset(rst[0]), .commit_valid(cv[0]), .commit_pc(cpc[0]),
        .rf_raddr(ra[0]), .rf_rdata(rfd[0]), .dump_valid(dv[0]), .dump_ready(rdy[0]),
        .dump_index(di[0]), .dump_data(dd[0]), .cpu_freeze(frz[0]), .done(dn[0]),
        .timeout(to[0]), .cycle_count(cc[0])
    );

    commit_run_monitor #(.MAX_CYCLES(20)) dut_b (
        .clock(clock), .reset(rst[1]), .commit_valid(cv[1]), .commit_pc(cpc[1]),
        .rf_raddr(ra[1]), .rf_rdata(rfd[1]), .dump_valid(dv[1]), .dump_ready(rdy[1]),
        .dump_index(di[1]), .dump_data(dd[1]), .cpu_freeze(frz[1]), .done(dn[1]),
        .timeout(to[1]), .cycle_count(cc[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int idx, input logic [31:0] w0,
                                             input logic [31:0] cyc_e, input logic [31:0] ret_e);
        if (idx == 0) return w0;
        else if (idx < 32) return 32'(idx) * 32'h11;
        else if (idx == 32) return cyc_e;
        else return ret_e;
    endfunction

    task automatic check_reset(input int d);
        check_eq("rst_raddr",  64'(ra[d]),  64'd1);
        check_eq("rst_valid",  64'(dv[d]),  64'd0);
        check_eq("rst_index",  64'(di[d]),  64'd0);
        check_eq("rst_data",   64'(dd[d]),  64'd0);
        check_eq("rst_freeze", 64'(frz[d]), 64'd0);
        check_eq("rst_done",   64'(dn[d]),  64'd0);
        check_eq("rst_tmo",    64'(to[d]),  64'd0);
        check_eq("rst_count",  64'(cc[d]),  64'd0);
    endtask

    // Called at a negedge; checks the asynchronous clear and releases at the next negedge.
    task automatic apply_reset(input int d);
        rst[d] = 1'b1;
        cv[d]  = 1'b0;
        rdy[d] = 1'b0;
        #2;
        check_reset(d);
        @(negedge clock);
        rst[d] = 1'b0;
    endtask

    task automatic drive_run(input int d, input int ncyc, input logic [31:0] base,
                             input bit halt_last, input logic [31:0] idle_mask, input bit exp_to);
        for (int i = 0; i < ncyc; i++) begin
            cv[d]  = !idle_mask[i];
            cpc[d] = (halt_last && i == ncyc - 1) ? 32'h48 : base + 32'(4 * i);
            if (i == ncyc - 1) begin
                check_eq("count_at_trigger", 64'(cc[d]), 64'(ncyc - 1));
                check_eq("run_freeze", 64'(frz[d]), 64'd0);
            end
            @(negedge clock);
        end
        cv[d] = 1'b0;
        check_eq("dump_freeze", 64'(frz[d]), 64'd1);
        check_eq("dump_first_valid", 64'(dv[d]), 64'd0);
        check_eq("timeout_flag", 64'(to[d]), 64'(exp_to));
        check_eq("count_frozen", 64'(cc[d]), 64'(ncyc));
    endtask

    task automatic collect(input int d, input bit bp, input int nstop, input logic [31:0] w0,
                           input logic [31:0] cyc_e, input logic [31:0] ret_e);
        int          got;
        int          last_t;
        bit          stall;
        logic [5:0]  pidx;
        logic [31:0] pdata;
        got = 0;
        last_t = -1;
        stall = 1'b0;
        pidx = '0;
        pdata = '0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clock);
            if (t == 0) check_eq("valid_latency", 64'(dv[d]), 64'd1);
            if (stall) check_eq("hold_stable", 64'({dv[d], di[d], dd[d]}), 64'({1'b1, pidx, pdata}));
            rdy[d] = bp ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
            if (dv[d] && rdy[d]) begin
                check_eq("word_index", 64'(di[d]), 64'(got));
                check_eq("word_data", 64'(dd[d]), 64'(exp_word(got, w0, cyc_e, ret_e)));
                got = got + 1;
            end
            stall = dv[d] && !rdy[d];
            pidx  = di[d];
            pdata = dd[d];
            if (got == nstop) begin
                last_t = t;
                break;
            end
        end
        check_eq("dump_count", 64'(got), 64'(nstop));
        if (!bp) check_eq("throughput", 64'(last_t), 64'(nstop - 1));
    endtask

    task automatic finish_check(input int d);
        @(negedge clock);
        check_eq("done_set", 64'(dn[d]), 64'd1);
        check_eq("done_valid_low", 64'(dv[d]), 64'd0);
        check_eq("done_freeze", 64'(frz[d]), 64'd1);
        @(negedge clock);
        check_eq("done_sticky", 64'(dn[d]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            cv[k]  = 1'b0;
            cpc[k] = '0;
            rdy[k] = 1'b0;
        end
        @(negedge clock);
        check_reset(1);
        apply_reset(0);

        // Halt at PC 0x48 after commits 0x0..0x48, ready always high.
        drive_run(0, 19, 32'h0, 1'b1, 32'h0, 1'b0);
        collect(0, 1'b0, NW, 32'h48, 32'd19, 32'd19);
        finish_check(0);

        // Backpressure with ready pattern 1,0,0,1.
        apply_reset(0);
        drive_run(0, 19, 32'h0, 1'b1, 32'h0, 1'b0);
        collect(0, 1'b1, NW, 32'h48, 32'd19, 32'd19);
        finish_check(0);

        // Reset in the middle of the dump, then a full rerun.
        apply_reset(0);
        drive_run(0, 19, 32'h0, 1'b1, 32'h0, 1'b0);
        collect(0, 1'b0, 10, 32'h48, 32'd19, 32'd19);
        apply_reset(0);
        drive_run(0, 19, 32'h0, 1'b1, 32'h0, 1'b0);
        collect(0, 1'b0, NW, 32'h48, 32'd19, 32'd19);
        finish_check(0);

        // Cycle-limit timeout: last committed PC is 0x100 + 4*19.
        apply_reset(1);
        drive_run(1, 20, 32'h100, 1'b0, 32'h0, 1'b1);
        collect(1, 1'b0, NW, 32'h14C, 32'd20, 32'd20);
        finish_check(1);

        // Halt and limit in the same cycle: halt wins.
        apply_reset(1);
        drive_run(1, 20, 32'h200, 1'b1, 32'h0, 1'b0);
        collect(1, 1'b0, NW, 32'h48, 32'd20, 32'd20);
        finish_check(1);

`ifdef PERF_COUNT_EN
        // 18 commits in 20 cycles, the last being the halt.
        apply_reset(0);
        drive_run(0, 20, 32'h300, 1'b1, 32'h0000_0088, 1'b0);
        collect(0, 1'b0, NW, 32'h48, 32'd20, 32'd18);
        finish_check(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_run_monitor.md
# commit_run_monitor

- Synthesizable run controller for the pipelined CPU; replaces the fixed halt-PC/cycle-limit logic in the simulation bench.
- Watches the write-back stage's committed PC and counts cycles.
- On a halt PC or cycle-limit timeout, freezes and streams a register-file snapshot out over a valid/ready port.
- Usable both in simulation and on FPGA, with a UART or logic analyser as the consumer.

## Interface
Parameters:
- XLEN, 32: datapath and PC width.
- NREGS, 32: architectural registers dumped; power of two, ≥ 2.
- CNT_W, 32: cycle/retire counter width.
- HALT_PC, 32'h0000_0048: committed PC that ends the run.
- MAX_CYCLES, 1000: cycle limit; must be ≥ 1 and < 2^CNT_W.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- commit_valid  in  1  a valid instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- rf_raddr  out  log2(NREGS)  register-file debug read address.
- rf_rdata  in  XLEN  combinational read data for rf_raddr.
- dump_valid  out  1  dump_data holds a word.
- dump_ready  in  1  consumer accepts the word.
- dump_index  out  log2(NREGS)+1  index of the current word.
- dump_data  out  XLEN  snapshot word.
- cpu_freeze  out  1  stall request to the CPU; high outside RUN.
- done  out  1  dump complete; sticky until reset.
- timeout  out  1  run ended by the cycle limit; sticky.
- cycle_count  out  CNT_W  cycles spent in RUN.

## Operation
FSM has three states: RUN, DUMP, DONE. Reset enters RUN.

RUN:
- cycle_count increments every cycle.
- If commit_valid and commit_pc == HALT_PC: go to DUMP, timeout=0, latch halt_pc_q = commit_pc.
- Otherwise, if cycle_count == MAX_CYCLES-1: go to DUMP, timeout=1, halt_pc_q = last committed PC (0 if none).
- If halt and limit occur in the same cycle, halt wins and timeout stays 0.

DUMP:
- cpu_freeze=1; cycle_count holds.
- Word order is index 0 = halt_pc_q, then indices 1..NREGS-1 = r1..r(NREGS-1). r0 is never read.
- Words are loaded into the registered dump_data/dump_index.
- rf_raddr always presents the index of the next word to load.
- After the last word's handshake, go to DONE.

DONE:
- cpu_freeze=1, done=1, dump_valid=0; held until reset.

Handshake rules:
- A word transfers when dump_valid && dump_ready.
- While dump_valid=1 and dump_ready=0, dump_data and dump_index are held stable.
- dump_valid never drops without a handshake.

Reset mid-DUMP: all outputs clear asynchronously; after release the FSM restarts in RUN with count 0.

## Timing
- Reset values: rf_raddr=1, dump_valid=0, dump_index=0, dump_data=0, cpu_freeze=0, done=0, timeout=0, cycle_count=0.
- RUN→DUMP is taken on the clock edge after the trigger cycle; cpu_freeze rises in that same cycle.
- dump_valid rises one cycle after DUMP is entered, carrying word 0.
- Throughput: one word per cycle with dump_ready held high. The next word is loaded on the same edge as the handshake.
- Dump length with dump_ready always high: NREGS cycles of dump_valid, plus 2 words with PERF_COUNT_EN.
- done rises the cycle after the last handshake.
- rf_rdata is sampled on the edge where a word is loaded. The register file must be stable under cpu_freeze.

## Configuration
- PERF_COUNT_EN defined:
  - Adds a retired-instruction counter (CNT_W bits) that increments on commit_valid in RUN. A halting commit counts.
  - Appends two words: index NREGS = cycle_count, index NREGS+1 = retired count.
- PERF_COUNT_EN undefined:
  - No retire counter; the dump ends at index NREGS-1.
  - dump_index MSB is tied to 0.

## Structure
Shared package, commit_mon_pkg, holds:
- State enum {RUN, DUMP, DONE}.
- Word-index constants: HDR_IDX=0, PERF_CYC_IDX=NREGS, PERF_RET_IDX=NREGS+1.
- Index-width function clog2.

Sub-module dump_stream_reg:
- One-entry output register with valid/ready hold logic.
- Instantiated once; the FSM drives its load strobe.

## Test plan
- Halt: commit PC sequence 0x0,0x4,…,0x48 with valid every cycle → DUMP entered, timeout=0, word0=0x48, words 1..31 = preloaded rf values (rk = k*0x11), done after 32 handshakes.
- Timeout: MAX_CYCLES=20, halt PC never committed → cycle_count=19 at trigger, timeout=1, word0 = last committed PC.
- Simultaneous: HALT_PC committed exactly at cycle MAX_CYCLES-1 → timeout=0, word0=HALT_PC.
- Backpressure: dump_ready toggled 1,0,0,1 per cycle → dump_data/dump_index stable while stalled, no word lost or repeated, indices 0..31 in order.
- Reset mid-dump at word 10 → all outputs at reset values asynchronously; rerun from RUN gives a full dump.
- With PERF_COUNT_EN, halt after 18 commits in 20 cycles → words 32 and 33 equal 20 and 18.
